// File: rtl/multi_timer_pkg.sv
// multi_timer_pkg: shared types and defaults for the multi_timer block.
//   channel_state_t : per-channel run state (IDLE / RUN / DONE)
//   *_DEF           : default values for NUM_CH, WIDTH and PRESC_W
//   sel_w()         : width of a channel select; at least 1 bit, so NUM_CH=1 still builds
package multi_timer_pkg;
  localparam int NUM_CH_DEF  = 4;
  localparam int WIDTH_DEF   = 32;
  localparam int PRESC_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } channel_state_t;

  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/multi_timer_if.sv
// multi_timer_if: terminal-count write bus.
//   max_we    : write strobe
//   max_sel   : channel addressed by the write (values >= NUM_CH are ignored)
//   max_wdata : new terminal count
// Modports: master drives the bus, slave (the timer) receives it.
interface multi_timer_if
  import multi_timer_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int WIDTH  = WIDTH_DEF
) ();
  localparam int SEL_W = sel_w(NUM_CH);

  logic             max_we;
  logic [SEL_W-1:0] max_sel;
  logic [WIDTH-1:0] max_wdata;

  modport master (output max_we, max_sel, max_wdata);
  modport slave  (input  max_we, max_sel, max_wdata);
endinterface

// File: rtl/multi_timer_channel.sv
// timer_channel: one interval timer channel.
//   clk, nrst : clock, async active-low reset
//   tick      : shared prescaler tick
//   enable    : run enable (level); low forces IDLE and count 0
//   oneshot   : 1 = stop in DONE after the first expiry, 0 = periodic
//   max       : terminal count (0 = never fires)
//   ack       : pending clear pulse
//   count     : live count
//   fire      : expiry pulse, combinational
//   pending   : sticky pending flag, registered
module timer_channel
  import multi_timer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             tick,
  input  logic             enable,
  input  logic             oneshot,
  input  logic [WIDTH-1:0] max,
  input  logic             ack,
  output logic [WIDTH-1:0] count,
  output logic             fire,
  output logic             pending
);
  channel_state_t   state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             pending_q, pending_d;
  logic             max_nz;
  logic [WIDTH-1:0] max_m1;
  logic             expire;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      pending_q <= pending_d;
    end
  end

  // Expiry uses >= so a terminal count shrunk below the live count expires
  // on the next tick instead of wrapping around.
  always_comb begin
    max_nz = (max != '0);
    max_m1 = max_nz ? (max - WIDTH'(1)) : '0;
    expire = (state_q == RUN) && tick && max_nz && (count_q >= max_m1);
    // Disable wins over a coincident expiry: no pulse, no pending.
    fire   = expire && enable;
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    pending_d = fire | (pending_q & ~ack);  // set beats ack
    if (!enable) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = RUN;
          count_d = '0;
        end
        RUN: begin
          if (expire) begin
            count_d = '0;
            if (oneshot) state_d = DONE;
          end else if (!max_nz) begin
            count_d = '0;
          end else if (tick) begin
            count_d = count_q + WIDTH'(1);
          end
        end
        DONE:    count_d = '0;
        default: begin
          state_d = IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  assign count   = count_q;
  assign pending = pending_q;
endmodule

// File: rtl/multi_timer.sv
// multi_timer: bank of NUM_CH interval timers sharing one prescaler.
//   clk, nrst   : clock, async active-low reset
//   enable      : per-channel run enable
//   oneshot     : per-channel mode (1 = one-shot)
//   prescale    : tick every prescale+1 clocks
//   wr          : terminal-count write bus (multi_timer_if.slave)
//   irq_ack     : per-channel pending clear
//   fire        : per-channel expiry pulse (combinational)
//   irq_pending : sticky per-channel pending
//   irq         : OR of irq_pending
//   count       : live counts, channel i at [i*WIDTH +: WIDTH]
// Build option MULTI_TIMER_PRESCALER_EN: when undefined the tick is constant
// 1, no prescaler counter exists and prescale is ignored.
module multi_timer
  import multi_timer_pkg::*;
#(
  parameter int NUM_CH  = NUM_CH_DEF,
  parameter int WIDTH   = WIDTH_DEF,
  parameter int PRESC_W = PRESC_W_DEF
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic [NUM_CH-1:0]       enable,
  input  logic [NUM_CH-1:0]       oneshot,
  input  logic [PRESC_W-1:0]      prescale,
  multi_timer_if.slave            wr,
  input  logic [NUM_CH-1:0]       irq_ack,
  output logic [NUM_CH-1:0]       fire,
  output logic [NUM_CH-1:0]       irq_pending,
  output logic                    irq,
  output logic [NUM_CH*WIDTH-1:0] count
);
  logic                         tick;
  logic [NUM_CH-1:0][WIDTH-1:0] max_q, max_d;
  logic [NUM_CH-1:0][WIDTH-1:0] ch_count;

`ifdef MULTI_TIMER_PRESCALER_EN
  logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;

  assign tick = (presc_cnt_q == prescale);

  // Held at 0 while the whole bank is idle so every start has the same phase.
  always_comb begin
    presc_cnt_d = presc_cnt_q + PRESC_W'(1);
    if (!(|enable) || tick) presc_cnt_d = '0;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) presc_cnt_q <= '0;
    else       presc_cnt_q <= presc_cnt_d;
  end
`else
  logic unused_prescale;
  assign unused_prescale = ^prescale;
  assign tick = 1'b1;
`endif

  // Select values with no matching channel simply hit no register.
  always_comb begin
    max_d = max_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (wr.max_we && (int'(wr.max_sel) == i)) max_d[i] = wr.max_wdata;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) max_q <= '0;
    else       max_q <= max_d;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    timer_channel #(.WIDTH(WIDTH)) u_ch (
      .clk     (clk),
      .nrst    (nrst),
      .tick    (tick),
      .enable  (enable[g]),
      .oneshot (oneshot[g]),
      .max     (max_q[g]),
      .ack     (irq_ack[g]),
      .count   (ch_count[g]),
      .fire    (fire[g]),
      .pending (irq_pending[g])
    );
  end

  assign count = ch_count;
  assign irq   = |irq_pending;
endmodule

// File: doc/multi_timer.md
# multi_timer

Parametrised bank of NUM_CH independent interval timers sharing one prescaler. It feeds the interrupt handler with per-channel sticky pending flags and a combined interrupt line. Each channel runs periodic or one-shot, with a runtime-writable terminal count. Pending flags are cleared by explicit acknowledge.

## Interface
- NUM_CH, 4: number of timer channels (1..16)
- WIDTH, 32: counter and terminal-count width
- PRESC_W, 8: prescaler width
- clk  in  1  clock
- nrst  in  1  reset, asynchronous, active-low
- enable  in  NUM_CH  per-channel run enable, level
- oneshot  in  NUM_CH  per-channel mode: 1 = one-shot, 0 = periodic
- prescale  in  PRESC_W  tick every prescale+1 clocks
- max_we  in  1  terminal-count write strobe
- max_sel  in  $clog2(NUM_CH)  channel addressed by the write
- max_wdata  in  WIDTH  terminal-count value
- irq_ack  in  NUM_CH  per-channel pending clear, one-cycle pulse
- fire  out  NUM_CH  per-channel expiry pulse, combinational, 1 cycle
- irq_pending  out  NUM_CH  sticky per-channel pending, registered
- irq  out  1  OR of irq_pending
- count  out  NUM_CH*WIDTH  live per-channel counts, channel i at [i*WIDTH +: WIDTH]

## Operation
- Prescaler:
  - presc_cnt increments every clock.
  - tick = (presc_cnt == prescale); presc_cnt returns to 0 on tick.
  - presc_cnt is forced to 0 while all enable bits are 0.
- Per-channel state machine, channel_state_t:
  - IDLE: count held 0. Goes to RUN at the first edge with enable=1.
  - RUN: count += 1 on edges with tick, except on expiry.
  - Expiry: tick && (max != 0) && (count >= max-1). fire=1 and count becomes 0 at that edge.
    - Periodic: stays in RUN.
    - One-shot: goes to DONE.
  - DONE: count held 0, fire never asserts. Leaves only through enable=0.
  - enable=0 from any state: next state IDLE, count 0. This includes a cycle that is also an expiry cycle: disable wins, no pending set.
- The expiry comparison is >=, so shrinking max below the current count causes expiry on the next tick, never a wrap-around.
- max = 0: the channel counts nothing and never fires. Count is held at 0 while in RUN.
- max = 1: fires on every tick.
- Terminal-count register:
  - Written at the edge where max_we=1.
  - Takes effect for the comparison in the following cycle.
  - Reset value 0.
  - An out-of-range max_sel (>= NUM_CH) is ignored.
- irq_pending[i]:
  - Set at the edge following fire[i].
  - Cleared by irq_ack[i].
  - fire and ack in the same cycle: set wins, pending stays 1.
- Count arithmetic is WIDTH bits unsigned, with no carry out. max-1 is computed only when max != 0.

## Timing
- Reset values: count 0, terminal counts 0, all states IDLE, presc_cnt 0, irq_pending 0, irq 0, fire 0.
- Reset applied mid-count returns everything to reset values immediately (asynchronous reset).
- From enable rising before edge E0, with prescale=0 and max=M:
  - state is RUN after E0.
  - count reaches M-1 after edge E0+(M-1).
  - fire is high in the following cycle.
  - irq_pending is high one edge later.
- Periodic period: M*(prescale+1) clocks between fire pulses.
- irq is derived from registered irq_pending, so it has zero added latency beyond pending.

## Configuration
- MULTI_TIMER_PRESCALER_EN:
  - Defined: prescaler behaves as above.
  - Undefined: tick is constant 1. No presc_cnt register is built, and the prescale port is present but ignored.

## Structure
- Package multi_timer_pkg holds:
  - channel_state_t enum {IDLE, RUN, DONE}
  - localparam defaults for NUM_CH, WIDTH and PRESC_W
- Sub-module timer_channel, one instance per channel, generated:
  - Inputs: clk, nrst, tick, enable, oneshot, max, ack.
  - Outputs: count, fire, pending.
  - Holds the state machine, count and pending.
- Top-level multi_timer holds the prescaler, the terminal-count register file, the write decode and the irq OR reduction.

## Test plan
- Periodic, prescale=0:
  - Stimulus: ch0 max=4, enable at E0.
  - Required: fire[0] after E3, E7, E11, exactly 4 clocks apart. irq_pending[0] rises after E4; irq=1.
- Prescaler (macro defined):
  - Stimulus: prescale=2, ch1 max=3, periodic.
  - Required: fire[1] every 9 clocks. count[1] steps only on every third edge.
- One-shot:
  - Stimulus: ch2 max=2, oneshot=1.
  - Required: a single fire; state DONE, count 0. No further fire over 50 clocks. Toggling enable 0→1 re-arms and gives one more fire.
- Ack race:
  - Stimulus: irq_ack[0] asserted in the same cycle as fire[0].
  - Required: pending stays 1. An ack in a later cycle clears it, and irq drops when no other channel is pending.
- Boundary:
  - Stimulus: ch3 running with count=10, then max written to 5. Separately, max=0.
  - Required: max=5 gives expiry on the next tick and count 0, no wrap. max=0 gives no fire over 100 clocks.
- Reset mid-operation:
  - Stimulus: nrst pulsed low while channels count and pending is set.
  - Required: all outputs 0 immediately. Terminal counts read back as 0, and no fire follows until max is rewritten.
